vme_cmd_sequencer: RTL and testbench

- Arbitrates between NREQ internal requesters (VME-stimulus reader, self-test engine, slow-control poller) that need to issue single 16-bit VME register read/write transactions.
- Sequences each granted request onto the shared VME command interface: vme_cmd_reg, vme_dat_reg_in, start, vme_cmd_rd, vme_dat_wr, vme_dat_reg_out.
- Handles the ready, issue and response handshake, applies the fixed command mask, and times out when a response never arrives.

---
 rtl/vme_cmd_sequencer.sv | 148 ++++++++++++++
 tb/tb_vme_cmd_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vme_cmd_sequencer.sv
// vme_cmd_sequencer: round-robin arbiter that sequences single 16-bit VME register
// transactions onto the shared command interface, with a saturating response timeout.
module vme_cmd_sequencer #(
    parameter int          NREQ     = 2,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] CMD_MASK = 32'h00A80000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_rnw,
    input  logic [16*NREQ-1:0] req_addr,
    input  logic [16*NREQ-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [15:0]        rd_data,
    output logic               timeout_err,
    output logic               busy,
    input  logic               vme_cmd_rd,
    input  logic               vme_dat_wr,
    input  logic [31:0]        vme_dat_reg_out,
    output logic               start,
    output logic [31:0]        vme_cmd_reg,
    output logic [31:0]        vme_dat_reg_in
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, own_q, own_d, sel, idx;
    logic            rnw_q, rnw_d, hit, grant;
    logic [15:0]     addr_q, addr_d, data_q, data_d, cnt_q, cnt_d, rd_q, rd_d;
    logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic            err_q, err_d, busy_q, busy_d, start_q, start_d;
    logic [31:0]     cmd_q, cmd_d, dat_q, dat_d;
    logic            unused_hi;

    assign unused_hi = ^vme_dat_reg_out[31:16];

    // Later loop iterations win, so scanning k downwards leaves the nearest requester after ptr.
    always_comb begin
        sel = ptr_q;
        idx = ptr_q;
        hit = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (req[idx]) begin
                sel = idx;
                hit = 1'b1;
            end
        end
    end

    assign grant = (state_q == IDLE) && vme_cmd_rd && hit;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        rd_d    = rd_q;
        start_d = 1'b0;
        cmd_d   = cmd_q;
        dat_d   = dat_q;
        if (state_q == IDLE) begin
            busy_d = grant;
            cmd_d  = CMD_MASK;
            dat_d  = '0;
            if (grant) begin
                state_d = ISSUE;
                ptr_d   = sel;
                own_d   = sel;
                rnw_d   = req_rnw[sel];
                addr_d  = req_addr[sel*16 +: 16];
                data_d  = req_data[sel*16 +: 16];
                gnt_d   = NREQ'(1) << sel;
            end
        end else if (state_q == ISSUE) begin
            state_d = WAIT;
            start_d = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
            cmd_d   = CMD_MASK | {6'b0, rnw_q, ~rnw_q, 8'h00, addr_q};
            dat_d   = {16'h0000, data_q};
        end else if (vme_dat_wr || cnt_q == TLAST) begin
            // A response arriving on the timeout cycle takes priority over the abort.
            state_d = IDLE;
            done_d  = NREQ'(1) << own_q;
            err_d   = !vme_dat_wr;
            rd_d    = vme_dat_wr ? (rnw_q ? vme_dat_reg_out[15:0] : 16'h0000) : 16'hFFFF;
            cmd_d   = CMD_MASK;
            dat_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NREQ - 1);
            own_q   <= '0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= '0;
            start_q <= 1'b0;
            cmd_q   <= CMD_MASK;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            start_q <= start_d;
            cmd_q   <= cmd_d;
            dat_q   <= dat_d;
        end
    end

    assign gnt            = gnt_q;
    assign done           = done_q;
    assign rd_data        = rd_q;
    assign timeout_err    = err_q;
    assign busy           = busy_q;
    assign start          = start_q;
    assign vme_cmd_reg    = cmd_q;
    assign vme_dat_reg_in = dat_q;
endmodule

// File: tb/tb_vme_cmd_sequencer.sv
// tb_vme_cmd_sequencer: table-driven cycle vectors plus directed multi-cycle sequences
// (round-robin, timeout, response/timeout collision, reset mid-transaction).
module tb_vme_cmd_sequencer;
    localparam logic [31:0] M  = 32'h00A80000;
    localparam logic [31:0] W0 = 32'h01A84100;
    localparam logic [31:0] R1 = 32'h02A83000;
    localparam logic [31:0] D0 = 32'h000000FF;
    localparam logic [31:0] D1 = 32'h00005555;

    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  req = '0, gnt, done;
    logic [1:0]  req_rnw = 2'b10;
    logic [31:0] req_addr = {16'h3000, 16'h4100};
    logic [31:0] req_data = {16'h5555, 16'h00FF};
    logic [15:0] rd_data;
    logic        timeout_err, busy, start;
    logic        crd = 1'b1, dwr = 1'b0;
    logic [31:0] rout = '0, cmd, dat;

    typedef struct packed {
        logic [1:0]  req;
        logic        crd;
        logic        dwr;
        logic [15:0] rout;
        logic [1:0]  gnt;
        logic [1:0]  done;
        logic        start;
        logic        busy;
        logic        err;
        logic [15:0] rd;
        logic [31:0] cmd;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl [19];
    int n_cmp = 0, n_bad = 0;

    vme_cmd_sequencer #(.NREQ(2), .TIMEOUT(8), .CMD_MASK(32'h00A80000)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rnw(req_rnw), .req_addr(req_addr),
        .req_data(req_data), .gnt(gnt), .done(done), .rd_data(rd_data),
        .timeout_err(timeout_err), .busy(busy), .vme_cmd_rd(crd), .vme_dat_wr(dwr),
        .vme_dat_reg_out(rout), .start(start), .vme_cmd_reg(cmd), .vme_dat_reg_in(dat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, id, act, exp);
        end
    endtask

    initial begin
        int exp_own, nd, lat;
        logic inflight;
        //             req  crd   dwr   rout      gnt    done   strt  busy  err   rd        cmd dat
        tbl[0]  = '{2'b01, 1'b1, 1'b0, 16'h0000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, M,  32'h0};
        tbl[1]  = '{2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 16'h0000, W0, D0};
        tbl[2]  = '{2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, W0, D0};
        tbl[3]  = '{2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, W0, D0};
        tbl[4]  = '{2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, W0, D0};
        tbl[5]  = '{2'b00, 1'b1, 1'b1, 16'h1234, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 16'h0000, M,  32'h0};
        tbl[6]  = '{2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, M,  32'h0};
        tbl[7]  = '{2'b10, 1'b1, 1'b0, 16'h0000, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, M,  32'h0};
        tbl[8]  = '{2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 16'h0000, R1, D1};
        tbl[9]  = '{2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, R1, D1};
        tbl[10] = '{2'b00, 1'b1, 1'b1, 16'hBEEF, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 16'hBEEF, M,  32'h0};
        tbl[11] = '{2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'hBEEF, M,  32'h0};
        tbl[12] = '{2'b01, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'hBEEF, M,  32'h0};
        tbl[13] = '{2'b01, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'hBEEF, M,  32'h0};
        tbl[14] = '{2'b01, 1'b1, 1'b0, 16'h0000, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 16'hBEEF, M,  32'h0};
        tbl[15] = '{2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 16'hBEEF, W0, D0};
        tbl[16] = '{2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 16'hBEEF, W0, D0};
        tbl[17] = '{2'b00, 1'b1, 1'b1, 16'hBEEF, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 16'h0000, M,  32'h0};
        tbl[18] = '{2'b00, 1'b1, 1'b0, 16'h0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, M,  32'h0};

        repeat (2) tick();
        check("rst_start", 0, start, 0);
        check("rst_gnt", 0, gnt, 0);
        check("rst_done", 0, done, 0);
        check("rst_err", 0, timeout_err, 0);
        check("rst_busy", 0, busy, 0);
        check("rst_rd", 0, rd_data, 0);
        check("rst_cmd", 0, cmd, M);
        check("rst_dat", 0, dat, 0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            req = tbl[i].req; crd = tbl[i].crd; dwr = tbl[i].dwr; rout = {16'h0000, tbl[i].rout};
            tick();
            check("tbl_gnt", i, gnt, tbl[i].gnt);
            check("tbl_done", i, done, tbl[i].done);
            check("tbl_start", i, start, tbl[i].start);
            check("tbl_busy", i, busy, tbl[i].busy);
            check("tbl_err", i, timeout_err, tbl[i].err);
            check("tbl_rd", i, rd_data, tbl[i].rd);
            check("tbl_cmd", i, cmd, tbl[i].cmd);
            check("tbl_dat", i, dat, tbl[i].dat);
        end

        // round-robin with both requesters held high, fresh reset so requester 0 leads
        rst = 1'b1; req = 2'b00; dwr = 1'b0; crd = 1'b1;
        tick();
        rst = 1'b0; req = 2'b11;
        exp_own = 0; nd = 0; inflight = 1'b0;
        for (int c = 0; c < 200 && nd < 4; c++) begin
            tick();
            if (gnt != 2'b00) begin
                check("rr_gnt", c, gnt, 32'(1) << exp_own);
                check("rr_overlap", c, inflight, 0);
                inflight = 1'b1;
                exp_own = 1 - exp_own;
            end
            if (done != 2'b00) begin
                inflight = 1'b0;
                nd++;
            end
            dwr = start;
        end
        check("rr_count", 0, nd, 4);
        req = 2'b00; dwr = 1'b0;
        repeat (2) tick();

        // timeout on a read with no response
        req = 2'b10;
        tick();
        check("to_gnt", 0, gnt, 2'b10);
        req = 2'b00;
        tick();
        check("to_start", 0, start, 1);
        check("to_cmd", 0, cmd, R1);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done != 2'b00) begin
                lat = n;
                break;
            end
        end
        check("to_lat", 0, lat, 8);
        check("to_done", 0, done, 2'b10);
        check("to_err", 0, timeout_err, 1);
        check("to_rd", 0, rd_data, 16'hFFFF);
        check("to_cmd_idle", 0, cmd, M);
        tick();
        check("to_err_pulse", 0, timeout_err, 0);
        check("to_busy_clr", 0, busy, 0);

        // response lands on the exact timeout cycle: no error, read data returned
        req = 2'b10;
        tick();
        check("col_gnt", 0, gnt, 2'b10);
        req = 2'b00;
        tick();
        check("col_start", 0, start, 1);
        repeat (7) tick();
        check("col_nodone", 0, done, 0);
        dwr = 1'b1; rout = 32'hDEADCAFE;
        tick();
        dwr = 1'b0;
        check("col_done", 0, done, 2'b10);
        check("col_err", 0, timeout_err, 0);
        check("col_rd", 0, rd_data, 16'hCAFE);
        tick();

        // reset mid-WAIT, then both requesters: requester 0 must win
        req = 2'b01;
        tick();
        check("rw_gnt", 0, gnt, 2'b01);
        req = 2'b00;
        tick();
        check("rw_start", 0, start, 1);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check("rw_start_clr", 0, start, 0);
        check("rw_cmd", 0, cmd, M);
        check("rw_dat", 0, dat, 0);
        check("rw_busy", 0, busy, 0);
        check("rw_done", 0, done, 0);
        tick();
        rst = 1'b0; req = 2'b11;
        tick();
        check("rw_done_after", 0, done, 0);
        check("rw_gnt_first", 0, gnt, 2'b01);
        req = 2'b00;
        tick();
        dwr = 1'b1;
        tick();
        dwr = 1'b0;
        check("rw_fin_done", 0, done, 2'b01);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
